// File: rtl/uart_pkg.sv
// uart_pkg: UART constants and FSM state encodings.
// Shared by the ALU result transmitter and the future operand receiver.
package uart_pkg;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_BAUD_DIV   = 326;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;
endpackage

// File: rtl/baud_rate_gen.sv
// baud_rate_gen: free-running oversample tick, one clk high every BAUD_DIV clks.
// It is never re-phased, so TX and RX can share one instance.
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV
) (
    input  logic clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int NB_CNT = $clog2(BAUD_DIV);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(BAUD_DIV - 1);

    logic [NB_CNT-1:0] r_cnt;

    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) r_cnt <= '0;
        else       r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;

    assign o_tick = (r_cnt == CNT_LAST);
endmodule

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: latches the ALU result on start and sends it as one 8N1 frame, LSB first.
// o_tx is registered from the next state, so the line falls one clk after a start is accepted.
module alu_result_uart_tx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int BAUD_DIV   = UART_BAUD_DIV,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int NB_STOP    = 1
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_result,
    input  logic               i_tx_start,
    output logic               o_tx,
    output logic               o_tx_busy,
    output logic               o_tx_done
);
    localparam int NB_TICK = $clog2(OVERSAMPLE * NB_STOP);
    localparam int NB_BIT  = $clog2(NB_DATA);
    localparam logic [NB_TICK-1:0] TICK_BIT_LAST  = NB_TICK'(OVERSAMPLE - 1);
    localparam logic [NB_TICK-1:0] TICK_STOP_LAST = NB_TICK'(OVERSAMPLE * NB_STOP - 1);
    localparam logic [NB_BIT-1:0]  BIT_LAST       = NB_BIT'(NB_DATA - 1);

    logic               w_tick;
    logic [1:0]         r_state, w_state_nxt;
    logic [NB_DATA-1:0] r_shift, w_shift_nxt;
    logic [NB_BIT-1:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [NB_TICK-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic               r_tx, r_done, w_done_nxt;

    baud_rate_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk    (clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_tick_cnt_nxt = r_tick_cnt;
        w_done_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: if (i_tx_start) begin
                w_state_nxt    = ST_START;
                w_shift_nxt    = i_result;
                w_tick_cnt_nxt = '0;
            end
            ST_START: if (w_tick) begin
                w_tick_cnt_nxt = (r_tick_cnt == TICK_BIT_LAST) ? '0 : r_tick_cnt + 1'b1;
                if (r_tick_cnt == TICK_BIT_LAST) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_DATA: if (w_tick) begin
                w_tick_cnt_nxt = (r_tick_cnt == TICK_BIT_LAST) ? '0 : r_tick_cnt + 1'b1;
                if (r_tick_cnt == TICK_BIT_LAST) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_state_nxt   = (r_bit_cnt == BIT_LAST) ? ST_STOP : ST_DATA;
                end
            end
            ST_STOP: if (w_tick) begin
                w_tick_cnt_nxt = (r_tick_cnt == TICK_STOP_LAST) ? '0 : r_tick_cnt + 1'b1;
                if (r_tick_cnt == TICK_STOP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_tick_cnt <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
            r_tx       <= (w_state_nxt == ST_START) ? 1'b0 :
                          (w_state_nxt == ST_DATA)  ? w_shift_nxt[0] : 1'b1;
            r_done     <= w_done_nxt;
        end

    assign o_tx      = r_tx;
    assign o_tx_done = r_done;
    assign o_tx_busy = (r_state != ST_IDLE);
endmodule

// File: tb/tb_alu_result_uart_tx.sv
// tb_alu_result_uart_tx: directed frames on a 1-stop and a 2-stop instance, BAUD_DIV=4 (64 clks per bit).
// Each received line sample is compared against a bit-timeline rebuilt from the queued expected byte.
module tb_alu_result_uart_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] result1 = '0, result2 = '0;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic       tx1, busy1, done1, tx2, busy2, done2;
    logic [7:0] sb1[$], sb2[$];
    int         checks = 0, failures = 0;
    int         gap, ls, sr, errs;

    always #5 clk = ~clk;

    alu_result_uart_tx #(.NB_DATA(8), .BAUD_DIV(4), .OVERSAMPLE(16), .NB_STOP(1)) dut1 (
        .clk(clk), .i_rst(rst), .i_result(result1), .i_tx_start(start1),
        .o_tx(tx1), .o_tx_busy(busy1), .o_tx_done(done1)
    );

    alu_result_uart_tx #(.NB_DATA(8), .BAUD_DIV(4), .OVERSAMPLE(16), .NB_STOP(2)) dut2 (
        .clk(clk), .i_rst(rst), .i_result(result2), .i_tx_start(start2),
        .o_tx(tx2), .o_tx_busy(busy2), .o_tx_done(done2)
    );

    function automatic logic tx_of(input bit inst);
        return inst ? tx2 : tx1;
    endfunction
    function automatic logic busy_of(input bit inst);
        return inst ? busy2 : busy1;
    endfunction
    function automatic logic done_of(input bit inst);
        return inst ? done2 : done1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Captures one frame from the falling edge to the done pulse, then checks it bit by bit.
    task automatic rx_frame(input bit inst, input int ns, input string tag,
                            output int o_gap, output int o_lstart, output int o_stop_run);
        logic       s[$];
        int         t, n, mism, busy_err;
        logic [7:0] e_byte, got;
        t = 0; o_gap = 0; o_lstart = 0; o_stop_run = 0;
        do begin @(negedge clk); t++; end while (tx_of(inst) !== 1'b0 && t < 3000);
        o_gap = t;
        check({tag, " fall"}, tx_of(inst), 0);
        if (tx_of(inst) !== 1'b0) return;
        n = 0; busy_err = 0;
        while (done_of(inst) !== 1'b1 && n < 1500) begin
            s.push_back(tx_of(inst));
            if (busy_of(inst) !== 1'b1) busy_err++;
            @(negedge clk);
            n++;
        end
        check({tag, " done"}, done_of(inst), 1);
        check({tag, " busy_end"}, busy_of(inst), 0);
        check({tag, " busy_during"}, busy_err, 0);
        o_lstart = n - 64 * (8 + ns);
        check({tag, " start_len_ok"}, (o_lstart >= 61 && o_lstart <= 64), 1);
        check({tag, " sb_nonempty"}, (inst ? sb2.size() : sb1.size()) != 0, 1);
        e_byte = inst ? (sb2.size() != 0 ? sb2.pop_front() : 8'h00) : (sb1.size() != 0 ? sb1.pop_front() : 8'h00);
        mism = 0; got = '0;
        if (o_lstart >= 0) begin
            for (int i = 0; i < n; i++) begin
                logic e;
                e = (i < o_lstart) ? 1'b0 : (i < o_lstart + 512) ? e_byte[(i - o_lstart) / 64] : 1'b1;
                if (s[i] !== e) mism++;
            end
            for (int k = 0; k < 8; k++) got[k] = s[o_lstart + 64 * k + 32];
        end
        check({tag, " data"}, got, e_byte);
        check({tag, " waveform"}, mism, 0);
        for (int i = n - 1; i >= 0 && s[i] === 1'b1; i--) o_stop_run++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst tx", tx1, 1);
        check("rst busy", busy1, 0);
        check("rst done", done1, 0);
        check("rst tx2", tx2, 1);
        rst = 1'b0;

        // 1: idle line after reset
        errs = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) errs++;
        end
        check("t1 idle", errs, 0);

        // 2: single 0xA5 frame
        result1 = 8'hA5; start1 = 1'b1; sb1.push_back(8'hA5);
        fork
            rx_frame(1'b0, 1, "t2", gap, ls, sr);
            begin @(negedge clk); start1 = 1'b0; result1 = 8'h00; end
        join
        @(negedge clk);
        check("t2 done_once", done1, 0);

        // 3: start and result changes while busy are ignored
        result1 = 8'h3C; start1 = 1'b1; sb1.push_back(8'h3C);
        fork
            rx_frame(1'b0, 1, "t3", gap, ls, sr);
            begin
                @(negedge clk); start1 = 1'b0;
                repeat (99) @(negedge clk);
                result1 = 8'hFF; start1 = 1'b1;
                @(negedge clk); start1 = 1'b0;
            end
        join
        errs = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) errs++;
        end
        check("t3 one_frame", errs, 0);

        // 4: start held high gives back-to-back frames
        result1 = 8'h01; sb1.push_back(8'h01); sb1.push_back(8'h01);
        fork
            begin
                rx_frame(1'b0, 1, "t4a", gap, ls, sr);
                rx_frame(1'b0, 1, "t4b", gap, ls, sr);
                check("t4 gap", gap, 1);
            end
            begin start1 = 1'b1; repeat (700) @(negedge clk); start1 = 1'b0; end
        join
        @(negedge clk);
        check("t4 idle_after", busy1, 0);
        check("t4 done_low", done1, 0);

        // 5: async reset in the middle of data bit 3, then a clean frame
        result1 = 8'hC3; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (288) @(negedge clk);
        check("t5 pre_rst tx", tx1, 0);
        check("t5 pre_rst busy", busy1, 1);
        rst = 1'b1;
        #1;
        check("t5 rst tx", tx1, 1);
        check("t5 rst busy", busy1, 0);
        check("t5 rst done", done1, 0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        result1 = 8'h81; start1 = 1'b1; sb1.push_back(8'h81);
        fork
            rx_frame(1'b0, 1, "t5", gap, ls, sr);
            begin @(negedge clk); start1 = 1'b0; end
        join

        // 6: two stop bits on the second instance
        result2 = 8'h00; start2 = 1'b1; sb2.push_back(8'h00);
        fork
            rx_frame(1'b1, 2, "t6", gap, ls, sr);
            begin @(negedge clk); start2 = 1'b0; end
        join
        check("t6 stop_len", sr, 128);
        check("t6 start_len", (ls >= 61 && ls <= 64), 1);
        @(negedge clk);
        check("t6 done_once", done2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
